// File: rtl/banked_memory_pkg.sv
// Shared constants and types for the TPU scratchpad memories.
package tpu_mem_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 10;

   // Which requester wins the next same-bank collision
   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_sel_e;

endpackage

// File: rtl/banked_memory_sram.sv
// One single-port bank: byte-strobed writes, synchronous read into a
// registered dout. dout only moves on a read, so a write leaves it alone.
module bank_sram #(
   parameter int DATA_W = 32,
   parameter int ROW_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_en,
   input  logic                  i_we,
   input  logic [ROW_W-1:0]      i_row,
   input  logic [DATA_W-1:0]     i_wdata,
   input  logic [DATA_W/8-1:0]   i_wstrb,
   output logic [DATA_W-1:0]     o_dout
);

   localparam int SW = DATA_W / 8;

   logic [DATA_W-1:0] r_mem [2**ROW_W];
   logic [DATA_W-1:0] r_dout;

   // Storage array: no reset, contents undefined at power-up
   always_ff @(posedge clk) begin
      if (i_en && i_we) begin
         for (int i = 0; i < SW; i++) begin
            if (i_wstrb[i]) r_mem[i_row][i*8 +: 8] <= i_wdata[i*8 +: 8];
         end
      end
   end

   // Read port register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              r_dout <= '0;
      else if (i_en && !i_we)  r_dout <= r_mem[i_row];
   end

   assign o_dout = r_dout;

endmodule

// File: rtl/banked_memory.sv
// Dual-port, word-interleaved scratchpad. Two requesters share NUM_BANKS
// single-port banks; same-bank collisions go round-robin and are counted.
module banked_memory
   import tpu_mem_pkg::*;
#(
   parameter int DATA_W    = DATA_WIDTH,
   parameter int ADDR_W    = ADDR_WIDTH,
   parameter int NUM_BANKS = 4,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 a_req_valid,
   output logic                 a_req_ready,
   input  logic                 a_we,
   input  logic [ADDR_W-1:0]    a_addr,
   input  logic [DATA_W-1:0]    a_wdata,
   input  logic [DATA_W/8-1:0]  a_wstrb,
   output logic                 a_rsp_valid,
   output logic [DATA_W-1:0]    a_rdata,
   input  logic                 b_req_valid,
   output logic                 b_req_ready,
   input  logic                 b_we,
   input  logic [ADDR_W-1:0]    b_addr,
   input  logic [DATA_W-1:0]    b_wdata,
   input  logic [DATA_W/8-1:0]  b_wstrb,
   output logic                 b_rsp_valid,
   output logic [DATA_W-1:0]    b_rdata,
   output logic [CNT_W-1:0]     conflict_cnt
);

   localparam int BB    = $clog2(NUM_BANKS);
   localparam int ROW_W = ADDR_W - BB;

   logic [BB-1:0]    w_a_bank, w_b_bank;
   logic             w_conf, w_a_acc, w_b_acc;
   port_sel_e        r_prio;
   logic [CNT_W-1:0] r_cnt;

   logic                              r_a_vld, r_b_vld;
   logic [BB-1:0]                     r_a_bank, r_b_bank;
   logic [DATA_W-1:0]                 r_a_last, r_b_last;

   logic [NUM_BANKS-1:0]              w_sel_a, w_sel_b, w_en, w_we;
   logic [NUM_BANKS-1:0][ROW_W-1:0]   w_row;
   logic [NUM_BANKS-1:0][DATA_W-1:0]  w_wdata, w_dout;
   logic [NUM_BANKS-1:0][DATA_W/8-1:0] w_wstrb;

   assign w_a_bank = a_addr[BB-1:0];
   assign w_b_bank = b_addr[BB-1:0];

   // A collision only restricts the loser; otherwise both ports are open
   assign w_conf      = a_req_valid && b_req_valid && (w_a_bank == w_b_bank);
   assign a_req_ready = !w_conf || (r_prio == PORT_A);
   assign b_req_ready = !w_conf || (r_prio == PORT_B);
   assign w_a_acc     = a_req_valid && a_req_ready;
   assign w_b_acc     = b_req_valid && b_req_ready;

   // Per-bank request steering; at most one port selects a given bank
   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      assign w_sel_a[g] = w_a_acc && (w_a_bank == BB'(g));
      assign w_sel_b[g] = w_b_acc && (w_b_bank == BB'(g));
      assign w_en[g]    = w_sel_a[g] || w_sel_b[g];
      assign w_we[g]    = w_sel_a[g] ? a_we    : b_we;
      assign w_row[g]   = w_sel_a[g] ? a_addr[ADDR_W-1:BB] : b_addr[ADDR_W-1:BB];
      assign w_wdata[g] = w_sel_a[g] ? a_wdata : b_wdata;
      assign w_wstrb[g] = w_sel_a[g] ? a_wstrb : b_wstrb;

      bank_sram #(.DATA_W(DATA_W), .ROW_W(ROW_W)) u_bank (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_en    (w_en[g]),
         .i_we    (w_we[g]),
         .i_row   (w_row[g]),
         .i_wdata (w_wdata[g]),
         .i_wstrb (w_wstrb[g]),
         .o_dout  (w_dout[g])
      );
   end

   // Round-robin priority and saturating collision counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prio <= PORT_A;
         r_cnt  <= '0;
      end else if (w_conf) begin
         r_prio <= (r_prio == PORT_A) ? PORT_B : PORT_A;
         if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Response tracking: which bank each port's pending read landed in.
   // The bank's dout can be overwritten by the other port later, so the
   // delivered word is latched to keep rdata stable between responses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_vld  <= 1'b0;
         r_b_vld  <= 1'b0;
         r_a_bank <= '0;
         r_b_bank <= '0;
         r_a_last <= '0;
         r_b_last <= '0;
      end else begin
         r_a_vld <= w_a_acc && !a_we;
         r_b_vld <= w_b_acc && !b_we;
         if (w_a_acc && !a_we) r_a_bank <= w_a_bank;
         if (w_b_acc && !b_we) r_b_bank <= w_b_bank;
         if (r_a_vld) r_a_last <= w_dout[r_a_bank];
         if (r_b_vld) r_b_last <= w_dout[r_b_bank];
      end
   end

   assign a_rsp_valid  = r_a_vld;
   assign b_rsp_valid  = r_b_vld;
   assign a_rdata      = r_a_vld ? w_dout[r_a_bank] : r_a_last;
   assign b_rdata      = r_b_vld ? w_dout[r_b_bank] : r_b_last;
   assign conflict_cnt = r_cnt;

endmodule

// File: doc/banked_memory.md
# banked_memory

Dual-port, bank-interleaved on-chip scratchpad. It is the parametrised successor to the single-bank 1R/1W memory. `NUM_BANKS` single-port SRAM banks are word-interleaved and shared by two requesters: port A (host/DMA load) and port B (systolic array fetch/drain). Requests use a valid/ready handshake with byte strobes and registered read data. Same-bank collisions are resolved by a round-robin arbiter, and a saturating counter records how often they occur.

## Interface
- `DATA_W`, default `DATA_WIDTH` (package): word width in bits; must be a multiple of 8.
- `ADDR_W`, default `ADDR_WIDTH` (package): word-address width for the whole memory.
- `NUM_BANKS`, default 4: number of banks; power of two, at least 2.
- `CNT_W`, default 16: width of the conflict counter.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a_req_valid` / `b_req_valid`  in  1  request present.
- `a_req_ready` / `b_req_ready`  out  1  request accepted this cycle when high together with valid.
- `a_we` / `b_we`  in  1  1 = write, 0 = read.
- `a_addr` / `b_addr`  in  ADDR_W  word address.
- `a_wdata` / `b_wdata`  in  DATA_W  write data.
- `a_wstrb` / `b_wstrb`  in  DATA_W/8  byte enables; ignored on reads.
- `a_rsp_valid` / `b_rsp_valid`  out  1  read data valid; single-cycle pulse.
- `a_rdata` / `b_rdata`  out  DATA_W  read data.
- `conflict_cnt`  out  CNT_W  saturating count of same-bank collisions.

## Operation
- **Bank mapping.** bank = `addr[BB-1:0]` and row = `addr[ADDR_W-1:BB]`, where BB = log2(NUM_BANKS). Consecutive words fall in consecutive banks.
- **Arbitration.** A conflict is both valids high with the same bank index.
  - No conflict: both readies follow their valids, and both banks are accessed in parallel.
  - Conflict: only the port named by the priority register `prio` (0 = A, 1 = B) gets ready. `prio` then flips to the other port. `conflict_cnt` increments and saturates at all-ones.
  - `prio` changes only on a conflict cycle.
- **Ready is combinational.** Ready depends on both valids and both addresses, and a port may see ready with valid low. A request held by a requester that lost arbitration must stay stable until accepted. Under continuous conflicts, round-robin guarantees acceptance within 2 cycles.
- **Writes.** Byte lane i of the row is updated only where `wstrb[i]` = 1. A write produces no response; acceptance is the acknowledge.
- **Reads.**
  - A read accepted in cycle N produces `rsp_valid` = 1 with `rdata` in cycle N+1.
  - Responses cannot be back-pressured.
  - `rdata` holds its last value while `rsp_valid` = 0.
  - Responses per port return in acceptance order (this follows from the fixed latency).
- **Ordering and coherency.**
  - A write accepted in cycle N is visible to any read accepted in cycle N+1 or later, on either port.
  - Two accesses to the same word in the same cycle are impossible, because same word implies same bank, which implies a conflict.
- **Unused banks.** A bank not selected by any accepted request keeps its enable low.

## Timing
- **Reset values:** all `rsp_valid` = 0, all `rdata` = 0, `conflict_cnt` = 0, `prio` = 0 (A first). Memory contents are not reset and are undefined after power-up.
- **Ready after reset:** readies are combinational from inputs and state, so they are valid immediately after reset release.
- **Reset asserted mid-operation:** any read accepted in the cycle before reset produces no response. State clears asynchronously.
- **Latency:** read 1 cycle; write 0 cycles to acceptance and 1 cycle to visibility.
- **Throughput:** two accesses per cycle when banks differ; one per cycle when they conflict.

## Structure
- **Shared package `tpu_mem_pkg`:** `DATA_WIDTH` and `ADDR_WIDTH` constants, plus the `port_sel_e` enum {PORT_A, PORT_B} used for `prio`.
- **Sub-module `bank_sram`:** single-port, byte-strobed, synchronous-read bank with a registered `dout`. It is instantiated `NUM_BANKS` times with generate.
- **Top level:** arbiter, per-bank request muxing, and per-port response muxing. The response mux selects using the bank index registered at acceptance.

## Test plan
Use DATA_W = 32, ADDR_W = 10, NUM_BANKS = 4.
1. **Reset:** hold `rst_n` low, then release. Required: `rsp_valid` = 0, `rdata` = 0, `conflict_cnt` = 0. A single A request is accepted in the first cycle after release.
2. **Parallel access:**
   - A writes 0xDEADBEEF to addr 0x004 while B writes 0x12345678 to addr 0x005. Both readies are high in the same cycle.
   - Next cycle, A reads 0x005 and B reads 0x004.
   - One cycle later: `a_rdata` = 0x12345678 and `b_rdata` = 0xDEADBEEF, both with `rsp_valid` = 1.
3. **Byte strobes:** write 0xAABBCCDD to addr 0x010, then write 0x11223344 to the same address with `wstrb` = 4'b0101. A subsequent read returns 0xAA22CC44.
4. **Conflict round-robin:**
   - A and B read addr 0x008 and 0x00C (both bank 0) continuously for 4 cycles.
   - Required: accepted port sequence A, B, A, B.
   - `conflict_cnt` = 4; `rsp_valid` alternates between ports one cycle after each acceptance.
5. **Write-then-read visibility:**
   - A writes 0x5A5A5A5A to addr 0x3FF in cycle N, and B reads addr 0x3FF in cycle N+1.
   - `b_rdata` = 0x5A5A5A5A in cycle N+2.
6. **Counter saturation and reset mid-read:**
   - With CNT_W = 4, force 20 conflicts. `conflict_cnt` holds at 15.
   - Then accept a read and assert `rst_n` low the next cycle. No `rsp_valid` appears, and `conflict_cnt` = 0.
